// File: rtl/mult_pipe_hs_if.sv
// mult_pipe_hs_if: operand/result stream bundle for mult_pipe_hs.
// The master side is the producer/consumer pair; the slave side is the multiplier.
interface mult_pipe_hs_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic                     in_vld;
    logic                     in_rdy;
    logic [N-1:0]             mult1;
    logic [M-1:0]             mult2;
    logic                     out_vld;
    logic                     out_rdy;
    logic [N+M-1:0]           res;
    logic                     busy;
    logic [$clog2(M+1)-1:0]   inflight;

    modport master (
        output in_vld, mult1, mult2, out_rdy,
        input  in_rdy, out_vld, res, busy, inflight
    );

    modport slave (
        input  in_vld, mult1, mult2, out_rdy,
        output in_rdy, out_vld, res, busy, inflight
    );
endinterface

// File: rtl/mult_pipe_hs.sv
// mult_pipe_hs: fully pipelined shift-add multiplier with valid/ready on both sides.
// Stage k consumes multiplier bit k-1; stage M is the output register, so latency
// and capacity are both M. Empty stages are filled from upstream (bubble-collapsing).
// Build macro SIGNED_MULT_EN: two's complement operands, last stage subtracts.
module mult_pipe_hs #(
    parameter int N = 8,
    parameter int M = 4
) (
    input logic           clk,
    input logic           rstn,
    mult_pipe_hs_if.slave bus
);
    localparam int W  = N + M;
    localparam int CW = $clog2(M + 1);

    logic [M:1]    r_vld;
    logic [W-1:0]  r_acc   [1:M];
    logic [W-1:0]  r_mcand [1:M];
    logic [M-1:0]  r_mplr  [1:M];
    logic [CW-1:0] r_inflight;

    // w_go[k]: stage k may load this cycle; w_go[M+1] is the consumer's ready.
    logic [M+1:1]  w_go;
    logic [M:1]    w_drain;
    logic [M:1]    w_load;
    logic [W-1:0]  w_ext;
    logic [W-1:0]  w_part;
    logic [W-1:0]  w_acc_in   [1:M];
    logic [W-1:0]  w_mcand_in [1:M];
    logic [M-1:0]  w_mplr_in  [1:M];
    logic          w_unused;

    // Ready chain from the consumer back to the producer; in_vld never feeds in_rdy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_go      = '0;
        w_drain   = '0;
        w_load    = '0;
        w_go[M+1] = bus.out_rdy;
        for (int k = M; k >= 1; k--) begin
            w_drain[k] = r_vld[k] && w_go[k+1];
            w_go[k]    = !r_vld[k] || w_drain[k];
        end
        w_load[1] = bus.in_vld && w_go[1];
        for (int k = 2; k <= M; k++) begin
            w_load[k] = w_drain[k-1];
        end
    end

    // Next contents of every stage: entry from the operands, then one partial product per stage.
    always_comb begin
`ifdef SIGNED_MULT_EN
        w_ext = {{M{bus.mult1[N-1]}}, bus.mult1};
`else
        w_ext = {{M{1'b0}}, bus.mult1};
`endif
        w_part        = '0;
        w_mcand_in[1] = w_ext;
        w_mplr_in[1]  = bus.mult2;
        w_acc_in[1]   = bus.mult2[0] ? w_ext : '0;
`ifdef SIGNED_MULT_EN
        if (M == 1) begin
            w_acc_in[1] = bus.mult2[0] ? ('0 - w_ext) : '0;
        end
`endif
        for (int k = 2; k <= M; k++) begin
            w_mcand_in[k] = r_mcand[k-1];
            w_mplr_in[k]  = r_mplr[k-1];
            w_part        = r_mplr[k-1][k-1] ? (r_mcand[k-1] << (k - 1)) : '0;
`ifdef SIGNED_MULT_EN
            // The sign bit of a two's complement multiplier carries weight -2^(M-1).
            w_acc_in[k]   = (k == M) ? (r_acc[k-1] - w_part) : (r_acc[k-1] + w_part);
`else
            w_acc_in[k]   = r_acc[k-1] + w_part;
`endif
        end
    end

    // Pipeline stages: load from upstream, drain to downstream, or hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_vld <= '0;
            // NOTE: stage data is cleared too, so res reads 0 after reset rather than stale data.
            for (int k = 1; k <= M; k++) begin
                r_acc[k]   <= '0;
                r_mcand[k] <= '0;
                r_mplr[k]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage read its neighbour's old value.
            for (int k = 1; k <= M; k++) begin
                if (w_load[k]) begin
                    r_vld[k]   <= 1'b1;
                    r_acc[k]   <= w_acc_in[k];
                    r_mcand[k] <= w_mcand_in[k];
                    r_mplr[k]  <= w_mplr_in[k];
                end else if (w_drain[k]) begin
                    r_vld[k]   <= 1'b0;
                end
            end
        end
    end

    // Occupancy: +1 per accept, -1 per delivered result, unchanged when both happen.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_inflight <= '0;
        end else if (w_load[1] && !w_drain[M]) begin
            r_inflight <= r_inflight + CW'(1);
        end else if (!w_load[1] && w_drain[M]) begin
            r_inflight <= r_inflight - CW'(1);
        end
    end

    assign bus.in_rdy   = w_go[1];
    assign bus.out_vld  = r_vld[M];
    assign bus.res      = r_acc[M];
    assign bus.inflight = r_inflight;
    assign bus.busy     = (r_inflight != '0);

    // The last stage's multiplicand and multiplier have no further consumer.
    assign w_unused = ^{r_mcand[M], r_mplr[M]};
endmodule
